// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: integer writeback select and
// the FP double-split sequencer state.
package wb_pkg;

  localparam logic [1:0] WRCTRL_NONE = 2'b00;
  localparam logic [1:0] WRCTRL_ALU  = 2'b01;
  localparam logic [1:0] WRCTRL_MEM  = 2'b10;

  typedef enum logic {
    WB_RUN = 1'b0,
    WB_LO  = 1'b1
  } wbState_t;

endpackage

// File: rtl/wb_writeback_unit_if.sv
// MEM/WB register to writeback-stage link; memWrWrite flows back to hold
// the MEM/WB register while a double-precision result is being split.
interface wb_writeback_unit_if;
  logic [31:0] aluResultWb;
  logic [31:0] memDataWb;
  logic [4:0]  rWWb;
  logic [1:0]  wrCtrlWb;
  logic [63:0] fp_busW;
  logic [4:0]  fp_rWWb;
  logic        fp_regWr;
  logic        fp_dbl;
  logic        memWrWrite;

  modport master (
    output aluResultWb, memDataWb, rWWb, wrCtrlWb,
    output fp_busW, fp_rWWb, fp_regWr, fp_dbl,
    input  memWrWrite
  );

  modport slave (
    input  aluResultWb, memDataWb, rWWb, wrCtrlWb,
    input  fp_busW, fp_rWWb, fp_regWr, fp_dbl,
    output memWrWrite
  );
endinterface

// File: rtl/fp_dword_sequencer.sv
// Drives the 32-bit FP register-file write port, splitting a 64-bit result
// into high half (even reg) then low half (odd reg) over two cycles.
//
// state  | meaning
// WB_RUN | accepting MEM/WB; singles and double high halves written here
// WB_LO  | MEM/WB ignored; held low half written to the odd register
module fp_dword_sequencer
  import wb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] fpBusW,
  input  logic [4:0]  fpRwWb,
  input  logic        fpRegWr,
  input  logic        fpDbl,
  output logic [31:0] fpWrData,
  output logic [4:0]  fpWrAddr,
  output logic        fpWrEn,
  output logic        memWrWrite,
  output logic        inRun
);

  wbState_t    state;
  logic [31:0] holdData;
  logic [4:0]  holdAddr;

  assign inRun      = (state == WB_RUN);
  assign memWrWrite = !(inRun && fpRegWr && fpDbl);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= WB_RUN;
      holdData <= '0;
      holdAddr <= '0;
      fpWrData <= '0;
      fpWrAddr <= '0;
      fpWrEn   <= 1'b0;
    end else begin
      case (state)
        WB_RUN: begin
          fpWrEn <= fpRegWr;
          if (fpRegWr && fpDbl) begin
            // Bit 0 of the destination is ignored: the pair is always {even, odd}
            fpWrAddr <= {fpRwWb[4:1], 1'b0};
            fpWrData <= fpBusW[63:32];
            holdAddr <= {fpRwWb[4:1], 1'b1};
            holdData <= fpBusW[31:0];
            state    <= WB_LO;
          end else if (fpRegWr) begin
            fpWrAddr <= fpRwWb;
            fpWrData <= fpBusW[31:0];
          end
        end
        WB_LO: begin
          fpWrEn   <= 1'b1;
          fpWrAddr <= holdAddr;
          fpWrData <= holdData;
          state    <= WB_RUN;
        end
        default: state <= WB_RUN;
      endcase
    end
  end

endmodule

// File: rtl/wb_writeback_unit.sv
// Writeback stage: integer result select and register-file write port,
// FP write port via the double-split sequencer, and a commit counter.
module wb_writeback_unit
  import wb_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  wb_writeback_unit_if.slave         memWb,
  output logic                       wb_stall,
  output logic [31:0]                busW,
  output logic [4:0]                 rW,
  output logic                       regWr,
  output logic [31:0]                fp_wrData,
  output logic [4:0]                 fp_wrAddr,
  output logic                       fp_wrEn,
  output logic [31:0]                wb_count
);

  logic inRun;
  logic seqMemWrWrite;
  logic intWr;

  fp_dword_sequencer uSeq (
    .clk        (clk),
    .rst_n      (rst_n),
    .fpBusW     (memWb.fp_busW),
    .fpRwWb     (memWb.fp_rWWb),
    .fpRegWr    (memWb.fp_regWr),
    .fpDbl      (memWb.fp_dbl),
    .fpWrData   (fp_wrData),
    .fpWrAddr   (fp_wrAddr),
    .fpWrEn     (fp_wrEn),
    .memWrWrite (seqMemWrWrite),
    .inRun      (inRun)
  );

  assign memWb.memWrWrite = seqMemWrWrite;
  assign wb_stall         = !seqMemWrWrite;

  assign intWr = ((memWb.wrCtrlWb == WRCTRL_ALU) || (memWb.wrCtrlWb == WRCTRL_MEM))
                 && (memWb.rWWb != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busW     <= '0;
      rW       <= '0;
      regWr    <= 1'b0;
      wb_count <= '0;
    end else if (inRun) begin
      regWr <= intWr;
      rW    <= memWb.rWWb;
      if (memWb.wrCtrlWb == WRCTRL_ALU)
        busW <= memWb.aluResultWb;
      else if (memWb.wrCtrlWb == WRCTRL_MEM)
        busW <= memWb.memDataWb;
      if (intWr || memWb.fp_regWr)
        wb_count <= wb_count + 32'd1;
    end else begin
      // Second half of a double: the instruction's integer write already happened
      regWr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Scoreboard bench for wb_writeback_unit: stimulus pushes expected writes,
// a negedge monitor pops and compares whenever a write enable is seen.
module tb_wb_writeback_unit;

  logic        clk;
  logic        rst_n;
  logic        wb_stall;
  logic [31:0] busW;
  logic [4:0]  rW;
  logic        regWr;
  logic [31:0] fp_wrData;
  logic [4:0]  fp_wrAddr;
  logic        fp_wrEn;
  logic [31:0] wb_count;

  wb_writeback_unit_if memWb ();

  wb_writeback_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .memWb     (memWb.slave),
    .wb_stall  (wb_stall),
    .busW      (busW),
    .rW        (rW),
    .regWr     (regWr),
    .fp_wrData (fp_wrData),
    .fp_wrAddr (fp_wrAddr),
    .fp_wrEn   (fp_wrEn),
    .wb_count  (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [36:0] intQ[$];
  logic [36:0] fpQ[$];
  logic [31:0] expCount = 0;

  task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every presented write must match the head of its queue.
  initial begin
    logic [36:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (regWr) begin
          if (intQ.size() == 0) begin
            checks++; errors++;
            $display("FAIL int_unexpected actual=%0d:%h required=none", rW, busW);
          end else begin
            e = intQ.pop_front();
            chk("int_write", {rW, busW}, e);
          end
        end
        if (fp_wrEn) begin
          if (fpQ.size() == 0) begin
            checks++; errors++;
            $display("FAIL fp_unexpected actual=%0d:%h required=none", fp_wrAddr, fp_wrData);
          end else begin
            e = fpQ.pop_front();
            chk("fp_write", {fp_wrAddr, fp_wrData}, e);
          end
        end
      end
    end
  end

  task automatic setIn(input logic [1:0] ctrl, input logic [4:0] rw, input logic [31:0] alu,
                       input logic [31:0] mem, input logic fw, input logic fd,
                       input logic [4:0] frw, input logic [63:0] fbus);
    memWb.wrCtrlWb    = ctrl;
    memWb.rWWb        = rw;
    memWb.aluResultWb = alu;
    memWb.memDataWb   = mem;
    memWb.fp_regWr    = fw;
    memWb.fp_dbl      = fd;
    memWb.fp_rWWb     = frw;
    memWb.fp_busW     = fbus;
  endtask

  task automatic idle();
    setIn(2'b00, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 64'h0);
  endtask

  // Presents one instruction, holding it while memWrWrite is low, like the MEM/WB register.
  task automatic issue(input string name, input logic [1:0] ctrl, input logic [4:0] rw,
                       input logic [31:0] alu, input logic [31:0] mem, input logic fw,
                       input logic fd, input logic [4:0] frw, input logic [63:0] fbus);
    logic isInt;
    setIn(ctrl, rw, alu, mem, fw, fd, frw, fbus);
    isInt = (ctrl == 2'b01 || ctrl == 2'b10) && (rw != 5'd0);
    if (isInt) intQ.push_back({rw, (ctrl == 2'b01) ? alu : mem});
    if (fw && fd) begin
      fpQ.push_back({frw[4:1], 1'b0, fbus[63:32]});
      fpQ.push_back({frw[4:1], 1'b1, fbus[31:0]});
    end else if (fw) begin
      fpQ.push_back({frw, fbus[31:0]});
    end
    if (isInt || fw) expCount = expCount + 32'd1;
    #1;
    chk({name, "_memWrWrite"}, {36'd0, memWb.memWrWrite}, {36'd0, !(fw && fd)});
    chk({name, "_wb_stall"}, {36'd0, wb_stall}, {36'd0, (fw && fd)});
    @(posedge clk); #1;
    if (fw && fd) begin
      chk({name, "_release"}, {36'd0, memWb.memWrWrite}, 37'd1);
      @(posedge clk); #1;
    end
    chk({name, "_count"}, {5'd0, wb_count}, {5'd0, expCount});
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #12;
    chk("rst_regWr", {36'd0, regWr}, 37'd0);
    chk("rst_fpWrEn", {36'd0, fp_wrEn}, 37'd0);
    chk("rst_int", {rW, busW}, 37'd0);
    chk("rst_fp", {fp_wrAddr, fp_wrData}, 37'd0);
    chk("rst_count", {5'd0, wb_count}, 37'd0);
    chk("rst_memWrWrite", {36'd0, memWb.memWrWrite}, 37'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue("alu5",    2'b01, 5'd5,  32'h1234, 32'h0,      0, 0, 5'd0, 64'h0);
    issue("memR0",   2'b10, 5'd0,  32'h0,    32'hDEAD,   0, 0, 5'd0, 64'h0);
    issue("mem10",   2'b10, 5'd10, 32'h9999, 32'hBEEF,   0, 0, 5'd0, 64'h0);
    issue("rsvd11",  2'b11, 5'd4,  32'h7777, 32'h8888,   0, 0, 5'd0, 64'h0);
    issue("dbl6",    2'b00, 5'd0,  32'h0,    32'h0,      1, 1, 5'd6, 64'hAAAA_BBBB_CCCC_DDDD);
    issue("dbl7int", 2'b01, 5'd3,  32'h55,   32'h0,      1, 1, 5'd7, 64'hAAAA_BBBB_CCCC_DDDD);
    issue("single9", 2'b00, 5'd0,  32'h0,    32'h0,      1, 0, 5'd9, 64'h1234_5678_3F80_0000);
    issue("dbl2",    2'b00, 5'd0,  32'h0,    32'h0,      1, 1, 5'd2, 64'h1111_2222_3333_4444);
    issue("dbl10",   2'b10, 5'd31, 32'h0,    32'hCAFE,   1, 1, 5'd10, 64'h0102_0304_0506_0708);
    issue("dbl13",   2'b00, 5'd0,  32'h0,    32'h0,      1, 1, 5'd13, 64'hF0F0_F0F0_0F0F_0F0F);
    idle();
    @(posedge clk); #1;
    chk("idle_count", {5'd0, wb_count}, {5'd0, expCount});

    // Reset while the low half of a double is pending: the low half must never appear.
    setIn(2'b00, 5'd0, 32'h0, 32'h0, 1'b1, 1'b1, 5'd20, 64'h5555_6666_7777_8888);
    fpQ.push_back({5'd20, 32'h5555_6666});
    @(posedge clk); #1;
    @(negedge clk); #1;
    rst_n = 1'b0;
    idle();
    #1;
    chk("midrst_regWr", {36'd0, regWr}, 37'd0);
    chk("midrst_fpWrEn", {36'd0, fp_wrEn}, 37'd0);
    chk("midrst_fp", {fp_wrAddr, fp_wrData}, 37'd0);
    chk("midrst_count", {5'd0, wb_count}, 37'd0);
    chk("midrst_memWrWrite", {36'd0, memWb.memWrWrite}, 37'd1);
    expCount = 0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_fpWrEn", {36'd0, fp_wrEn}, 37'd0);
    repeat (2) @(posedge clk);
    #1;
    issue("postrst_alu", 2'b01, 5'd1, 32'hFEED_F00D, 32'h0, 0, 0, 5'd0, 64'h0);
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("intQ_drained", {5'd0, 32'(intQ.size())}, 37'd0);
    chk("fpQ_drained", {5'd0, 32'(fpQ.size())}, 37'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
